// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared ALU port and the response channels.
// The arbiter uses the slave modport; the requesters and the ALU sit on the master side.
interface alu_arbiter_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTR_W  = 3;

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [CTR_W-1:0]  req0_ctr;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [CTR_W-1:0]  req1_ctr;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [CTR_W-1:0]  alu_ctr;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic [DATA_W-1:0] rsp0_result;
   logic              rsp0_zero;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp1_result;
   logic              rsp1_zero;

   logic              busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctr,
      input  req1_valid, req1_a, req1_b, req1_ctr,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_ctr,
      input  alu_result, alu_zero,
      output rsp0_valid, rsp0_result, rsp0_zero,
      output rsp1_valid, rsp1_result, rsp1_zero,
      input  rsp0_ready, rsp1_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctr,
      output req1_valid, req1_a, req1_b, req1_ctr,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_ctr,
      output alu_result, alu_zero,
      input  rsp0_valid, rsp0_result, rsp0_zero,
      input  rsp1_valid, rsp1_result, rsp1_zero,
      output rsp0_ready, rsp1_ready,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module alu_arbiter (
   input logic          clock,
   input logic          reset_n,
   alu_arbiter_if.slave bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTR_W  = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_accept;
   logic              w_owner_ready;

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [CTR_W-1:0]  r_ctr;
   logic              r_owner;
   logic              r_rsp0_valid;
   logic              r_rsp1_valid;
   logic [DATA_W-1:0] r_rsp0_result;
   logic [DATA_W-1:0] r_rsp1_result;
   logic              r_rsp0_zero;
   logic              r_rsp1_zero;
   logic              r_busy;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic              r_last;
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Grant selection and next-state
   always_comb begin
      w_state_nxt   = r_state;
      w_grant0      = 1'b0;
      w_grant1      = 1'b0;
      w_accept      = 1'b0;
      w_owner_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
      case (r_state)
         S_IDLE: begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            if (bus.req0_valid && bus.req1_valid) begin
               w_grant0 = r_last;
               w_grant1 = ~r_last;
            end else begin
               w_grant0 = bus.req0_valid;
               w_grant1 = bus.req1_valid;
            end
`else
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
            w_accept = w_grant0 | w_grant1;
            if (w_accept) w_state_nxt = S_EXEC;
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (w_owner_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, result capture and response handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_a           <= '0;
         r_b           <= '0;
         r_ctr         <= '0;
         r_owner       <= 1'b0;
         r_rsp0_valid  <= 1'b0;
         r_rsp1_valid  <= 1'b0;
         r_rsp0_result <= '0;
         r_rsp1_result <= '0;
         r_rsp0_zero   <= 1'b0;
         r_rsp1_zero   <= 1'b0;
         r_busy        <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         r_last        <= 1'b1;
`endif
      end else begin
         if (w_accept) begin
            r_a     <= w_grant1 ? bus.req1_a   : bus.req0_a;
            r_b     <= w_grant1 ? bus.req1_b   : bus.req0_b;
            r_ctr   <= w_grant1 ? bus.req1_ctr : bus.req0_ctr;
            r_owner <= w_grant1;
            r_busy  <= 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            r_last  <= w_grant1;
`endif
         end
         if (r_state == S_EXEC) begin
            if (r_owner) begin
               r_rsp1_result <= bus.alu_result;
               r_rsp1_zero   <= bus.alu_zero;
               r_rsp1_valid  <= 1'b1;
            end else begin
               r_rsp0_result <= bus.alu_result;
               r_rsp0_zero   <= bus.alu_zero;
               r_rsp0_valid  <= 1'b1;
            end
         end
         if ((r_state == S_RESP) && w_owner_ready) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
         end
      end
   end

   // Ready is a same-cycle grant; everything else comes straight from registers
   assign bus.req0_ready  = w_grant0;
   assign bus.req1_ready  = w_grant1;
   assign bus.alu_a       = r_a;
   assign bus.alu_b       = r_b;
   assign bus.alu_ctr     = r_ctr;
   assign bus.rsp0_valid  = r_rsp0_valid;
   assign bus.rsp1_valid  = r_rsp1_valid;
   assign bus.rsp0_result = r_rsp0_result;
   assign bus.rsp1_result = r_rsp1_result;
   assign bus.rsp0_zero   = r_rsp0_zero;
   assign bus.rsp1_zero   = r_rsp1_zero;
   assign bus.busy        = r_busy;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; widths fixed at 32-bit operands, 3-bit ALUctr.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N has an operation pending.
REQ-005 reqN_ready  out  1  requester N's operation is accepted this cycle.
REQ-006 reqN_a, reqN_b  in  32  operands A, B from requester N.
REQ-007 reqN_ctr  in  3  ALUctr code from requester N.
REQ-008 alu_a, alu_b  out  32  operands driven to the shared alu A/B ports.
REQ-009 alu_ctr  out  3  code driven to the shared alu ALUctr port.
REQ-010 alu_result  in  32  Result from the shared alu (combinational).
REQ-011 alu_zero  in  1  Zero from the shared alu.
REQ-012 rspN_valid  out  1  response for requester N available.
REQ-013 rspN_ready  in  1  requester N consumes its response.
REQ-014 rspN_result  out  32; rspN_zero  out  1  captured Result/Zero.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States IDLE, EXEC, RESP; exactly one active; IDLE after reset.
REQ-017 IDLE: grant at most one requester; reqN_ready = (state==IDLE) & grantN; accept on reqN_valid & reqN_ready.
REQ-018 Accept: capture reqN_a/b/ctr into operand registers, record owner N, go to EXEC next cycle.
REQ-019 alu_a/alu_b/alu_ctr driven only from operand registers, never combinationally from request inputs.
REQ-020 EXEC (exactly one cycle): capture alu_result/alu_zero into owner's response registers at end of cycle; go to RESP.
REQ-021 RESP: rspOwner_valid=1, other rsp_valid=0; hold result/zero stable until rspOwner_ready=1, then IDLE next cycle.
REQ-022 Latency: acceptance in cycle T -> rsp_valid first high in cycle T+2; max throughput one op per 3 cycles.
REQ-023 rspN_ready while rspN_valid=0 ignored; rsp_ready for non-owner ignored.
REQ-024 reqN_ready=0 in EXEC and RESP regardless of reqN_valid; pending requests wait, not dropped.
REQ-025 ALUctr codes passed unmodified, including unused codes 011/100/101; no checking.
REQ-026 Operand registers keep last op's values after completion (no clearing).
REQ-027 Single valid requester granted without regard to priority state.

Reset
REQ-028 reset_n=0 forces IDLE immediately, regardless of clock.
REQ-029 Reset values: alu_a=0, alu_b=0, alu_ctr=3'b000, rspN_valid=0, rspN_result=0, rspN_zero=0, busy=0, last-grant pointer=1.
REQ-030 Reset during EXEC/RESP discards in-flight op; no response issued after deassertion.
REQ-031 reqN_ready may assert in first clock after reset_n rises.

Configuration
REQ-032 Macro ALU_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-033 Defined: both valid in IDLE -> grant requester not granted last; pointer updates on every accept.
REQ-034 Undefined: both valid -> requester 0 always wins; pointer unused, requester 1 may starve.

Verification
REQ-035 req0 a=127,b=33,ctr=010, rsp0_ready=1 -> rsp0_valid at T+2, rsp0_result=160, zero=0.
REQ-036 req1 a=10,b=10,ctr=110 -> rsp1_result=0, rsp1_zero=1; rsp0_valid stays 0 throughout.
REQ-037 req0 ops 000/001/110/111 on 127,33 -> results 33, 127, 94, 0 in order, one op per 3 cycles.
REQ-038 Both valid continuously, ROUND_ROBIN_EN defined -> grants 0,1,0,1; undefined -> 0,0,0,0.
REQ-039 rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid/result stable, req0_ready and req1_ready held 0, busy=1.
REQ-040 reset_n=0 mid-EXEC -> outputs at reset values immediately; no rsp_valid after release until a new accept.
